// File: rtl/pyrm_fetch_queue.sv
// Instruction fetch unit with a DEPTH-entry {pc,inst} queue and branch predecode.
// Define PYRM_FETCH_JAL_REDIRECT_EN to redirect on JAL internally; otherwise JAL waits for branch_pc.
module pyrm_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h80000000,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               reset_pyri,
  input  logic [63:0]        branch_pc_pyri,
  input  logic               branch_pc_valid_pyri,
  output logic               branch_pc_retry_pyro,
  output logic               imem_req_pyro,
  output logic [IMEM_AW-1:0] imem_addr_pyro,
  input  logic [31:0]        imem_data_pyri,
  output logic [63:0]        pc_pyro,
  output logic               pc_valid_pyro,
  input  logic               pc_retry_pyri,
  output logic [31:0]        inst_pyro,
  output logic               inst_valid_pyro,
  input  logic               inst_retry_pyri,
  output logic               dbg_wait_branch_pyro
);

  // Handshakes: a transfer happens on a rising edge where valid is high and every
  // retry signal on that channel is low; valid data is held stable while retried.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic {RUNNING = 1'b0, WAIT_BRANCH = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [63:0]    fetch_pc_q, fetch_pc_d;
  logic           inflight_q, inflight_d;
  logic [63:0]    inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic [63:0]    pc_mem   [DEPTH];
  logic [31:0]    inst_mem [DEPTH];

  logic           space;
  logic           push;
  logic           pop;
  logic           req;
  logic [63:0]    req_pc;
  logic           branch_retry;
  logic [6:0]     opcode;
  logic           is_stall;

  assign opcode = imem_data_pyri[6:0];
  assign push   = inflight_q;
  // Occupancy counts the outstanding request so a response always has a slot.
  assign space  = (count_q + CW'(inflight_q)) < CW'(DEPTH);

`ifdef PYRM_FETCH_JAL_REDIRECT_EN
  logic        is_jal;
  logic [63:0] jal_imm;
  logic [63:0] jal_target;
  assign is_stall   = (opcode == OP_BRANCH) || (opcode == OP_JALR);
  assign is_jal     = (opcode == OP_JAL);
  assign jal_imm    = {{43{imem_data_pyri[31]}}, imem_data_pyri[31], imem_data_pyri[19:12],
                       imem_data_pyri[20], imem_data_pyri[30:21], 1'b0};
  assign jal_target = inflight_pc_q + jal_imm;
`else
  assign is_stall = (opcode == OP_BRANCH) || (opcode == OP_JALR) || (opcode == OP_JAL);
`endif

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    req           = 1'b0;
    req_pc        = fetch_pc_q;
    branch_retry  = 1'b1;
    case (state_q)
      RUNNING: begin
        if (inflight_q && is_stall) begin
          state_d = WAIT_BRANCH;
`ifdef PYRM_FETCH_JAL_REDIRECT_EN
        end else if (inflight_q && is_jal) begin
          if (space) begin
            req        = 1'b1;
            req_pc     = jal_target;
            fetch_pc_d = jal_target + 64'd4;
          end else begin
            fetch_pc_d = jal_target;
          end
`endif
        end else if (space) begin
          req        = 1'b1;
          fetch_pc_d = fetch_pc_q + 64'd4;
        end
      end
      WAIT_BRANCH: begin
        branch_retry = !space;
        if (branch_pc_valid_pyri && space) begin
          req        = 1'b1;
          req_pc     = branch_pc_pyri;
          fetch_pc_d = branch_pc_pyri + 64'd4;
          state_d    = RUNNING;
        end
      end
      default: state_d = RUNNING;
    endcase
    if (req) begin
      inflight_d    = 1'b1;
      inflight_pc_d = req_pc;
    end
  end

  // Outputs are forced to their idle values while reset is held.
  assign imem_req_pyro        = req && !reset_pyri;
  assign imem_addr_pyro       = req_pc[IMEM_AW+1:2];
  assign branch_pc_retry_pyro = branch_retry || reset_pyri;
  assign pc_valid_pyro        = (count_q != '0) && !reset_pyri;
  assign inst_valid_pyro      = pc_valid_pyro;
  assign pc_pyro              = pc_valid_pyro ? pc_mem[rd_ptr_q] : 64'd0;
  assign inst_pyro            = pc_valid_pyro ? inst_mem[rd_ptr_q] : 32'd0;
  assign dbg_wait_branch_pyro = (state_q == WAIT_BRANCH);

  assign pop      = pc_valid_pyro && !pc_retry_pyri && !inst_retry_pyri;
  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);
  assign count_d  = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or posedge reset_pyri) begin
    if (reset_pyri) begin
      state_q       <= RUNNING;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 64'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= inflight_pc_q;
      inst_mem[wr_ptr_q] <= imem_data_pyri;
    end
  end

endmodule

// File: tb/tb_pyrm_fetch_queue.sv
// Bench for pyrm_fetch_queue: architectural instruction-stream model, queue scoreboard,
// directed scenarios and randomized programs.
module tb_pyrm_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h80000000;
  localparam int          IMEM_AW  = 14;
  localparam logic [6:0]  OP_BR    = 7'b1100011;
  localparam logic [6:0]  OP_JALR  = 7'b1100111;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic               clk;
  logic               reset_pyri;
  logic [63:0]        branch_pc_pyri;
  logic               branch_pc_valid_pyri;
  logic               branch_pc_retry_pyro;
  logic               imem_req_pyro;
  logic [IMEM_AW-1:0] imem_addr_pyro;
  logic [31:0]        imem_data_pyri;
  logic [63:0]        pc_pyro;
  logic               pc_valid_pyro;
  logic               pc_retry_pyri;
  logic [31:0]        inst_pyro;
  logic               inst_valid_pyro;
  logic               inst_retry_pyri;
  logic               dbg_wait_branch_pyro;

  pyrm_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW)) dut (
    .clk                  (clk),
    .reset_pyri           (reset_pyri),
    .branch_pc_pyri       (branch_pc_pyri),
    .branch_pc_valid_pyri (branch_pc_valid_pyri),
    .branch_pc_retry_pyro (branch_pc_retry_pyro),
    .imem_req_pyro        (imem_req_pyro),
    .imem_addr_pyro       (imem_addr_pyro),
    .imem_data_pyri       (imem_data_pyri),
    .pc_pyro              (pc_pyro),
    .pc_valid_pyro        (pc_valid_pyro),
    .pc_retry_pyri        (pc_retry_pyri),
    .inst_pyro            (inst_pyro),
    .inst_valid_pyro      (inst_valid_pyro),
    .inst_retry_pyri      (inst_retry_pyri),
    .dbg_wait_branch_pyro (dbg_wait_branch_pyro)
  );

  typedef struct packed {logic [63:0] pc; logic [31:0] inst;} entry_t;
  typedef struct {int c; logic [63:0] pc;} log_t;

  entry_t      exp_q[$];
  log_t        req_log[$];
  logic [31:0] inst_tab [256];
  logic [63:0] tgt_tab  [256];
  int          jal_imm_tab [256];

  int          n_cmp = 0;
  int          n_fail = 0;

  logic [63:0] model_pc;
  bit          pend;
  int          pend_age;
  int          pend_delay;
  logic [63:0] pend_tgt;
  bit          req_prev;
  bit          resp_v_nxt;
  logic [31:0] resp_d_nxt;
  int          cyc, pops, reqs, first_req_cyc, first_valid_cyc, retry_low_cnt;
  int          br_delay_fixed;
  bit          rand_retry;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- architectural model ----------------
  function automatic bit is_stall_op(input logic [31:0] i);
`ifdef PYRM_FETCH_JAL_REDIRECT_EN
    return (i[6:0] == OP_BR) || (i[6:0] == OP_JALR);
`else
    return (i[6:0] == OP_BR) || (i[6:0] == OP_JALR) || (i[6:0] == OP_JAL);
`endif
  endfunction

  function automatic logic [63:0] next_pc(input logic [63:0] pc, input logic [31:0] i);
    if (i[6:0] == OP_BR || i[6:0] == OP_JALR) return tgt_tab[pc[9:2]];
    if (i[6:0] == OP_JAL) return pc + 64'(longint'(jal_imm_tab[pc[9:2]]));
    return pc + 64'd4;
  endfunction

  function automatic logic [31:0] enc_jal(input int imm);
    logic [20:0] b;
    b = imm[20:0];
    return {b[20], b[10:1], b[11], b[19:12], 5'd1, OP_JAL};
  endfunction

  // ---------------- driver: memory responses, branch targets, random retries ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      imem_data_pyri = resp_v_nxt ? resp_d_nxt : $urandom;
      if (pend && pend_age >= pend_delay) begin
        branch_pc_valid_pyri = 1'b1;
        branch_pc_pyri       = pend_tgt;
      end else begin
        branch_pc_valid_pyri = 1'b0;
        branch_pc_pyri       = {$urandom, $urandom};
      end
      if (rand_retry) begin
        pc_retry_pyri   = ($urandom_range(0, 99) < 30);
        inst_retry_pyri = ($urandom_range(0, 99) < 30);
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    int     sz;
    bit     sp, waiting, acc, e_req, e_valid;
    entry_t ent;
    log_t   lg;
    forever begin
      @(negedge clk);
      if (!reset_pyri) begin
        if (pend) pend_age++;
        sz      = exp_q.size();
        sp      = sz < DEPTH;
        waiting = pend && pend_age >= 2;
        acc     = waiting && branch_pc_valid_pyri && sp;
        e_req   = pend ? acc : sp;
        e_valid = (sz - int'(req_prev)) > 0;

        n_cmp++;
        if (imem_req_pyro !== e_req) begin
          n_fail++;
          $display("FAIL imem_req cyc %0d: got %0b want %0b", cyc, imem_req_pyro, e_req);
        end
        n_cmp++;
        if (branch_pc_retry_pyro !== !(waiting && sp)) begin
          n_fail++;
          $display("FAIL branch_retry cyc %0d: got %0b want %0b", cyc, branch_pc_retry_pyro, !(waiting && sp));
        end
        n_cmp++;
        if (pc_valid_pyro !== e_valid || inst_valid_pyro !== e_valid) begin
          n_fail++;
          $display("FAIL valid cyc %0d: got pc_valid %0b inst_valid %0b want %0b", cyc, pc_valid_pyro, inst_valid_pyro, e_valid);
        end
        n_cmp++;
        if (dbg_wait_branch_pyro !== waiting) begin
          n_fail++;
          $display("FAIL wait_state cyc %0d: got %0b want %0b", cyc, dbg_wait_branch_pyro, waiting);
        end
        if (e_valid && sz > 0) begin
          n_cmp++;
          if (pc_pyro !== exp_q[0].pc || inst_pyro !== exp_q[0].inst) begin
            n_fail++;
            $display("FAIL head cyc %0d: got pc %h inst %h want pc %h inst %h", cyc, pc_pyro, inst_pyro, exp_q[0].pc, exp_q[0].inst);
          end
        end
        if (!branch_pc_retry_pyro) retry_low_cnt++;
        if (pc_valid_pyro && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (pc_valid_pyro && !pc_retry_pyri && !inst_retry_pyri && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          pops++;
        end
        if (imem_req_pyro) begin
          if (pend) pend = 1'b0;
          n_cmp++;
          if (imem_addr_pyro !== model_pc[IMEM_AW+1:2]) begin
            n_fail++;
            $display("FAIL imem_addr cyc %0d: got %h want %h", cyc, imem_addr_pyro, model_pc[IMEM_AW+1:2]);
          end
          ent.pc   = model_pc;
          ent.inst = inst_tab[model_pc[9:2]];
          exp_q.push_back(ent);
          resp_d_nxt = inst_tab[imem_addr_pyro[7:0]];
          resp_v_nxt = 1'b1;
          lg.c  = cyc;
          lg.pc = model_pc;
          req_log.push_back(lg);
          reqs++;
          if (first_req_cyc < 0) first_req_cyc = cyc;
          if (is_stall_op(ent.inst)) begin
            pend       = 1'b1;
            pend_age   = 0;
            pend_tgt   = next_pc(model_pc, ent.inst);
            pend_delay = (br_delay_fixed >= 0) ? br_delay_fixed : int'($urandom_range(0, 5));
          end
          model_pc = next_pc(model_pc, ent.inst);
        end else begin
          resp_v_nxt = 1'b0;
        end
        req_prev = imem_req_pyro;
        cyc++;
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load_nops();
    for (int i = 0; i < 256; i++) begin
      inst_tab[i]    = NOP;
      tgt_tab[i]     = RESET_PC;
      jal_imm_tab[i] = 0;
    end
  endtask

  // Asserts reset mid-cycle, checks the idle output values at once, restarts the model.
  task automatic apply_reset();
    @(posedge clk);
    #3;
    reset_pyri = 1'b1;
    #1;
    n_cmp++;
    if (pc_valid_pyro !== 1'b0 || inst_valid_pyro !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %0b/%0b want 0/0", pc_valid_pyro, inst_valid_pyro);
    end
    n_cmp++;
    if (imem_req_pyro !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req: got %0b want 0", imem_req_pyro);
    end
    n_cmp++;
    if (branch_pc_retry_pyro !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_branch_retry: got %0b want 1", branch_pc_retry_pyro);
    end
    n_cmp++;
    if (pc_pyro !== 64'd0 || inst_pyro !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: got pc %h inst %h want 0/0", pc_pyro, inst_pyro);
    end
    exp_q.delete();
    req_log.delete();
    pend = 1'b0; pend_age = 0; req_prev = 1'b0; resp_v_nxt = 1'b0;
    model_pc = RESET_PC;
    pops = 0; reqs = 0; first_req_cyc = -1; first_valid_cyc = -1; retry_low_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_pyri = 1'b0;
    cyc = 0;
  endtask

  function automatic int find_req(input logic [63:0] pc);
    for (int i = 0; i < req_log.size(); i++) if (req_log[i].pc == pc) return i;
    return -1;
  endfunction

  task automatic test_reset();
    load_nops();
    apply_reset();
    run(3);
    n_cmp++;
    if (req_log.size() < 1 || req_log[0].pc !== RESET_PC || req_log[0].c != 0) begin
      n_fail++;
      $display("FAIL reset_first_req: got %0d entries want first at cycle 0 pc %h", req_log.size(), RESET_PC);
    end
  endtask

  task automatic test_sequential();
    load_nops();
    apply_reset();
    run(20);
    n_cmp++;
    if (first_valid_cyc - first_req_cyc != 2) begin
      n_fail++;
      $display("FAIL seq_latency: got %0d want 2", first_valid_cyc - first_req_cyc);
    end
    n_cmp++;
    if (pops != 18) begin
      n_fail++;
      $display("FAIL seq_throughput: got %0d pops want 18", pops);
    end
    n_cmp++;
    if (req_log.size() < 2 || req_log[1].pc !== RESET_PC + 64'd4) begin
      n_fail++;
      $display("FAIL seq_second_req: got %0d entries want second at %h", req_log.size(), RESET_PC + 64'd4);
    end
  endtask

  task automatic test_full_stall();
    load_nops();
    inst_retry_pyri = 1'b1;
    apply_reset();
    run(12);
    n_cmp++;
    if (reqs != 4) begin
      n_fail++;
      $display("FAIL full_reqs: got %0d want 4", reqs);
    end
    n_cmp++;
    if (pc_valid_pyro !== 1'b1 || pc_pyro !== RESET_PC) begin
      n_fail++;
      $display("FAIL full_head: got valid %0b pc %h want 1 %h", pc_valid_pyro, pc_pyro, RESET_PC);
    end
    inst_retry_pyri = 1'b0;
    run(6);
    n_cmp++;
    if (pops != 6 || reqs <= 4) begin
      n_fail++;
      $display("FAIL full_release: got pops %0d reqs %0d want pops 6 reqs >4", pops, reqs);
    end
  endtask

  task automatic test_jal();
    int a, b;
    load_nops();
    inst_tab[2]    = enc_jal(16);
    jal_imm_tab[2] = 16;
    br_delay_fixed = 4;
    apply_reset();
    run(12);
    a = find_req(RESET_PC + 64'h8);
    b = find_req(RESET_PC + 64'h18);
    n_cmp++;
    if (a < 0 || b != a + 1) begin
      n_fail++;
      $display("FAIL jal_order: got idx %0d/%0d want consecutive", a, b);
    end else begin
      n_cmp++;
`ifdef PYRM_FETCH_JAL_REDIRECT_EN
      if (req_log[b].c - req_log[a].c != 1) begin
        n_fail++;
        $display("FAIL jal_bubble: got gap %0d want 1", req_log[b].c - req_log[a].c);
      end
`else
      if (req_log[b].c - req_log[a].c != br_delay_fixed + 1) begin
        n_fail++;
        $display("FAIL jal_stall: got gap %0d want %0d", req_log[b].c - req_log[a].c, br_delay_fixed + 1);
      end
`endif
    end
  endtask

  task automatic test_branch();
    int a, b;
    load_nops();
    inst_tab[1]    = 32'h00000063;
    tgt_tab[1]     = RESET_PC + 64'h100;
    br_delay_fixed = 3;
    apply_reset();
    run(12);
    a = find_req(RESET_PC + 64'h4);
    b = find_req(RESET_PC + 64'h100);
    n_cmp++;
    if (a < 0 || b < 0 || req_log[b].c - req_log[a].c != 4) begin
      n_fail++;
      $display("FAIL branch_gap: got idx %0d/%0d want gap 4", a, b);
    end
    n_cmp++;
    if (b < 0 || b + 1 >= req_log.size() || req_log[b+1].pc !== RESET_PC + 64'h104 || req_log[b+1].c != req_log[b].c + 1) begin
      n_fail++;
      $display("FAIL branch_next: got idx %0d want %h next cycle", b, RESET_PC + 64'h104);
    end
    n_cmp++;
    if (retry_low_cnt != 3) begin
      n_fail++;
      $display("FAIL branch_retry_low: got %0d cycles want 3", retry_low_cnt);
    end
  endtask

  task automatic test_branch_full();
    int b;
    load_nops();
    inst_tab[3]     = 32'h00000067;
    tgt_tab[3]      = RESET_PC + 64'h200;
    br_delay_fixed  = 1;
    inst_retry_pyri = 1'b1;
    apply_reset();
    run(10);
    n_cmp++;
    if (reqs != 4 || branch_pc_valid_pyri !== 1'b1 || branch_pc_retry_pyro !== 1'b1) begin
      n_fail++;
      $display("FAIL bfull_hold: got reqs %0d valid %0b retry %0b want 4 1 1", reqs, branch_pc_valid_pyri, branch_pc_retry_pyro);
    end
    inst_retry_pyri = 1'b0;
    run(6);
    b = find_req(RESET_PC + 64'h200);
    n_cmp++;
    if (b < 0 || req_log[b].c < 10) begin
      n_fail++;
      $display("FAIL bfull_accept: got idx %0d want request at %h after release", b, RESET_PC + 64'h200);
    end
  endtask

  task automatic test_reset_midstream();
    load_nops();
    br_delay_fixed = 0;
    apply_reset();
    run(7);
    apply_reset();
    run(6);
    n_cmp++;
    if (first_req_cyc != 0 || first_valid_cyc != 2 || req_log.size() < 1 || req_log[0].pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL midreset_restart: got req %0d valid %0d want 0 2 at %h", first_req_cyc, first_valid_cyc, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    int          sel, imm;
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 256; i++) begin
        r              = $urandom;
        sel            = $urandom_range(0, 99);
        tgt_tab[i]     = RESET_PC + 64'(4 * $urandom_range(0, 255));
        jal_imm_tab[i] = 0;
        if (sel < 30)      inst_tab[i] = NOP;
        else if (sel < 55) inst_tab[i] = {r[31:7], 7'b0110011};
        else if (sel < 70) inst_tab[i] = {r[31:7], OP_BR};
        else if (sel < 80) inst_tab[i] = {r[31:7], OP_JALR};
        else begin
          imm = 4 * int'($urandom_range(1, 64));
          if ($urandom_range(0, 1) == 1) imm = -imm;
          jal_imm_tab[i] = imm;
          inst_tab[i]    = enc_jal(imm);
        end
      end
      br_delay_fixed = -1;
      rand_retry     = 1'b1;
      apply_reset();
      run(400);
      n_cmp++;
      if (pops < 40) begin
        n_fail++;
        $display("FAIL random_progress round %0d: got %0d pops want >= 40", round, pops);
      end
      rand_retry = 1'b0;
      #1;
      pc_retry_pyri   = 1'b0;
      inst_retry_pyri = 1'b0;
    end
  endtask

  initial begin
    reset_pyri           = 1'b0;
    branch_pc_pyri       = 64'd0;
    branch_pc_valid_pyri = 1'b0;
    imem_data_pyri       = 32'd0;
    pc_retry_pyri        = 1'b0;
    inst_retry_pyri      = 1'b0;
    rand_retry           = 1'b0;
    br_delay_fixed       = 0;
    pend = 1'b0; pend_age = 0; pend_delay = 0; pend_tgt = 64'd0;
    req_prev = 1'b0; resp_v_nxt = 1'b0; resp_d_nxt = 32'd0; model_pc = RESET_PC;
    cyc = 0; pops = 0; reqs = 0; first_req_cyc = -1; first_valid_cyc = -1; retry_low_cnt = 0;

    test_reset();
    test_sequential();
    test_full_stall();
    test_jal();
    test_branch();
    test_branch_full();
    test_reset_midstream();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pyrm_fetch_queue.md
PYRM_FETCH_QUEUE -- requirements
Module: pyrm_fetch_queue

Interface
REQ-001 Parameter DEPTH, 4, fetch-queue entries; power of two, >= 2.
REQ-002 Parameter RESET_PC, 64'h80000000, first fetch address after reset.
REQ-003 Parameter IMEM_AW, 14, instruction-memory word-address width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset_pyri  in  1  reset, asynchronous, active-high.
REQ-006 branch_pc_pyri  in  64  resolved branch/JALR target.
REQ-007 branch_pc_valid_pyri  in  1  target valid.
REQ-008 branch_pc_retry_pyro  out  1  target not accepted this cycle.
REQ-009 imem_req_pyro  out  1  instruction-memory read request.
REQ-010 imem_addr_pyro  out  IMEM_AW  word address = request PC[IMEM_AW+1:2]; upper PC bits ignored (wrap).
REQ-011 imem_data_pyri  in  32  read data, valid exactly one cycle after imem_req_pyro.
REQ-012 pc_pyro  out  64  PC of queue head.
REQ-013 pc_valid_pyro  out  1  queue head valid.
REQ-014 pc_retry_pyri  in  1  consumer stall, PC channel.
REQ-015 inst_pyro  out  32  instruction of queue head.
REQ-016 inst_valid_pyro  out  1  equals pc_valid_pyro.
REQ-017 inst_retry_pyri  in  1  consumer stall, instruction channel.

Function
REQ-018 Registers: fetch_pc (64), state {RUNNING, WAIT_BRANCH}, inflight flag + inflight_pc, FIFO of DEPTH {pc,inst} entries, count 0..DEPTH.
REQ-019 Space = (count + inflight) < DEPTH; simultaneous pop does not free space in the same cycle.
REQ-020 RUNNING, no response this cycle, space: imem_req_pyro=1 at fetch_pc; fetch_pc <= fetch_pc+4; inflight <= 1.
REQ-021 Response cycle (inflight=1): entry {inflight_pc, imem_data_pyri} enqueued; opcode = imem_data_pyri[6:0] predecoded combinationally.
REQ-022 Response opcode 7'b1100011 (branch) or 7'b1100111 (JALR): no request this cycle; state <= WAIT_BRANCH.
REQ-023 Response opcode 7'b1101111 (JAL): request this cycle (if space) at target = inflight_pc + sign-extended 21-bit J-immediate; fetch_pc <= target+4; if no space, fetch_pc <= target; zero-bubble redirect.
REQ-024 Other opcodes: normal sequential request per REQ-020.
REQ-025 WAIT_BRANCH: branch_pc_retry_pyro = !space; target accepted when branch_pc_valid_pyri && space: request at branch_pc_pyri same cycle, fetch_pc <= branch_pc_pyri+4, state <= RUNNING.
REQ-026 RUNNING: branch_pc_retry_pyro = 1; branch_pc_valid_pyri ignored.
REQ-027 Pop when pc_valid_pyro && !pc_retry_pyri && !inst_retry_pyri; either retry stalls both channels; head held stable while stalled.
REQ-028 Push and pop in same cycle: count unchanged; push when count=DEPTH cannot occur (REQ-019).
REQ-029 Latency: request cycle N -> response N+1 -> head visible N+2 when queue empty.
REQ-030 Pointers wrap modulo DEPTH; PC arithmetic modulo 2^64.

Reset
REQ-031 Asserting reset_pyri, at any time, immediately clears count, pointers, inflight; state=RUNNING; fetch_pc=RESET_PC.
REQ-032 During reset: pc_valid_pyro=0, inst_valid_pyro=0, imem_req_pyro=0, branch_pc_retry_pyro=1, pc_pyro=0, inst_pyro=0.
REQ-033 A response due the cycle after reset is discarded; first request issued in first cycle with reset low.

Configuration
REQ-034 Macro PYRM_FETCH_JAL_REDIRECT_EN defined: JAL handled per REQ-023.
REQ-035 Macro undefined: JAL treated as branch/JALR (REQ-022), target supplied on branch_pc_pyri.

Verification
REQ-036 Reset release, nops (32'h00000013), no retry -> requests at 0x80000000, 0x80000004, ...; first head pc 0x80000000 two cycles after first request, one instruction/cycle thereafter.
REQ-037 inst_retry_pyri held high, DEPTH=4 -> exactly 4 entries queued, imem_req_pyro low until a pop; head unchanged throughout.
REQ-038 JAL at 0x80000008 imm +16, macro defined -> next request at 0x80000018, no bubble; macro undefined -> stall until branch_pc_valid_pyri.
REQ-039 Branch at 0x80000004 -> no requests, branch_pc_retry_pyro=0; branch_pc 0x80000100 presented -> request same cycle, next at 0x80000104.
REQ-040 WAIT_BRANCH with full queue and branch_pc valid -> branch_pc_retry_pyro=1 until a pop frees space.
REQ-041 reset_pyri pulsed mid-stream with inflight request -> outputs invalid immediately, stale response not enqueued, restart at 0x80000000.
